binary_input_counter: RTL and testbench

- Front-end stage that produces the 4-bit binary value feeding the binary-to-7-segment decoder (its `binary_in`).
- Takes two raw push-buttons (increment and decrement) and a 4-bit slide-switch bank with a load switch.
- Debounces and edge-detects the buttons and maintains a wrap-around 4-bit up/down count, so the display steps 0..15 by button press.
- Pulses a wrap flag whenever the count rolls over 15->0 or 0->15.

---
 rtl/display_pkg.sv | 19 +
 rtl/button_debouncer.sv | 102 ++++++++++
 rtl/binary_input_counter.sv | 89 ++++++++
 tb/tb_binary_input_counter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the button front end and the 7-segment decoder stage.
package display_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd15;
   localparam int DB_CYCLES_DEFAULT = 16;

   // One displayed hex digit; also the decoder's binary_in type.
   typedef logic [DIGIT_W-1:0] digit_t;

   // Action applied to the count register in a given cycle.
   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_LOAD,
      STEP_INC,
      STEP_DEC
   } step_e;

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-flop synchronizer, debounce filter, press-edge detect
// and optional auto-repeat.
module button_debouncer
   import display_pkg::*;
#(
   parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
   parameter int RPT_DELAY  = 0,
   parameter int RPT_PERIOD = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press_evt,
   output logic level
);

   localparam int DB_W = $clog2(DB_CYCLES);

   logic [1:0]      sync;
   logic [DB_W-1:0] db_cnt;
   logic            stable;
   logic            stable_d;
   logic            rpt_fire;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], btn_raw};
      end
   end

   // Accept a new level only after it has differed from stable for DB_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
         stable <= 1'b0;
      end else if (sync[1] != stable) begin
         if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            stable <= sync[1];
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // Registered rising-edge detect merged with repeat ticks into one event pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable_d  <= 1'b0;
         press_evt <= 1'b0;
      end else begin
         stable_d  <= stable;
         press_evt <= (stable & ~stable_d) | rpt_fire;
      end
   end

   // level is taken after the edge register so it lines up with press_evt.
   assign level = stable_d;

   generate
      if (RPT_DELAY > 0) begin : g_repeat
         localparam int HOLD_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
         localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

         logic [HOLD_W-1:0] hold_cnt;
         logic              rpt_active;

         // Fire after the initial delay while held, then once per period.
         always_comb begin
            rpt_fire = 1'b0;
            if (stable) begin
               if (rpt_active) begin
                  rpt_fire = (hold_cnt == HOLD_W'(RPT_PERIOD - 1));
               end else begin
                  rpt_fire = (hold_cnt == HOLD_W'(RPT_DELAY - 1));
               end
            end
         end

         // Hold timer runs while the button is stably pressed; release clears it.
         always_ff @(posedge clk) begin
            if (rst || !stable) begin
               hold_cnt   <= '0;
               rpt_active <= 1'b0;
            end else if (rpt_fire) begin
               hold_cnt   <= '0;
               rpt_active <= 1'b1;
            end else begin
               hold_cnt   <= hold_cnt + HOLD_W'(1);
            end
         end
      end else begin : g_no_repeat
         assign rpt_fire = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/binary_input_counter.sv
// Up/down 4-bit digit driven by two debounced buttons and a switch-bank load.
module binary_input_counter
   import display_pkg::*;
#(
   parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
   parameter int RPT_DELAY  = 0,
   parameter int RPT_PERIOD = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_inc_raw,
   input  logic               btn_dec_raw,
   input  logic               load_en,
   input  logic [DIGIT_W-1:0] load_val,
   output logic [DIGIT_W-1:0] binary_out,
   output logic               wrap_pulse,
   output logic               busy
);

   logic   inc_evt;
   logic   dec_evt;
   logic   inc_level;
   logic   dec_level;
   step_e  step;
   digit_t count;

   button_debouncer #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
   ) u_inc (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_inc_raw),
      .press_evt(inc_evt),
      .level    (inc_level)
   );

   button_debouncer #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
   ) u_dec (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_dec_raw),
      .press_evt(dec_evt),
      .level    (dec_level)
   );

   // Pick this cycle's action: load beats events, opposing events cancel.
   always_comb begin
      step = STEP_HOLD;
      if (load_en) begin
         step = STEP_LOAD;
      end else if (inc_evt && !dec_evt) begin
         step = STEP_INC;
      end else if (dec_evt && !inc_evt) begin
         step = STEP_DEC;
      end
   end

   // Count register with roll-over flag; loads never flag a wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         wrap_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         busy       <= inc_level | dec_level;
         wrap_pulse <= 1'b0;
         case (step)
            STEP_LOAD: count <= load_val;
            STEP_INC: begin
               count      <= count + digit_t'(1);
               wrap_pulse <= (count == DIGIT_MAX);
            end
            STEP_DEC: begin
               count      <= count - digit_t'(1);
               wrap_pulse <= (count == '0);
            end
            default: count <= count;
         endcase
      end
   end

   assign binary_out = count;

endmodule

// File: tb/tb_binary_input_counter.sv
// Scoreboard bench: a timestamp-based model predicts every cycle's outputs for
// two DUT configurations (no repeat, and repeat 10/3) driven by shared stimulus.
module tb_binary_input_counter;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_inc_raw = 1'b0;
   logic       btn_dec_raw = 1'b0;
   logic       load_en = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] out0, out1;
   logic       wrap0, wrap1, busy0, busy1;

   always #5 clk = ~clk;

   binary_input_counter #(.DB_CYCLES(DB), .RPT_DELAY(0), .RPT_PERIOD(8)) dut0 (
      .clk(clk), .rst(rst), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
      .load_en(load_en), .load_val(load_val),
      .binary_out(out0), .wrap_pulse(wrap0), .busy(busy0)
   );

   binary_input_counter #(.DB_CYCLES(DB), .RPT_DELAY(10), .RPT_PERIOD(3)) dut1 (
      .clk(clk), .rst(rst), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
      .load_en(load_en), .load_val(load_val),
      .binary_out(out1), .wrap_pulse(wrap1), .busy(busy1)
   );

   typedef struct packed {
      logic [3:0] val;
      logic       wrap;
      logic       busy;
   } exp_t;

   exp_t expq0[$];
   exp_t expq1[$];
   int   checks = 0;
   int   passed = 0;

   // ---------------- reference model ----------------
   int  edge_n = 0;
   int  rd[2] = '{0, 10};
   int  rp[2] = '{8, 3};
   int  m_count[2];
   bit  m_wrap[2];
   bit  m_busy[2];
   bit  bh1[2], bh2[2];          // stable-or history, 1 and 2 edges back
   bit  seen1[2][2], seen2[2][2]; // raw samples 1 and 2 edges back
   bit  st[2][2];
   int  run[2][2];
   int  rise[2][2];
   bit  evr[2][2][4];            // events scheduled by edge number mod 4

   task automatic model_edge(input int d);
      bit raw[2];
      bit ev[2];
      bit seen;
      int n;
      n = edge_n;
      if (rst) begin
         m_count[d] = 0; m_wrap[d] = 0; m_busy[d] = 0; bh1[d] = 0; bh2[d] = 0;
         for (int b = 0; b < 2; b++) begin
            seen1[d][b] = 0; seen2[d][b] = 0; st[d][b] = 0; run[d][b] = 0; rise[d][b] = 0;
            for (int k = 0; k < 4; k++) evr[d][b][k] = 0;
         end
         return;
      end
      raw[0] = btn_inc_raw;
      raw[1] = btn_dec_raw;
      for (int b = 0; b < 2; b++) begin
         ev[b] = evr[d][b][n % 4];
         evr[d][b][n % 4] = 0;
         seen = seen2[d][b];
         seen2[d][b] = seen1[d][b];
         seen1[d][b] = raw[b];
         // repeat ticks at rise+RPT_DELAY+k*RPT_PERIOD while still held, applied one edge later
         if (rd[d] > 0 && st[d][b] && (n - rise[d][b]) >= rd[d] &&
             ((n - rise[d][b] - rd[d]) % rp[d]) == 0)
            evr[d][b][(n + 1) % 4] = 1;
         // a level is accepted once it has disagreed with stable for DB edges in a row
         if (seen != st[d][b]) begin
            run[d][b]++;
            if (run[d][b] == DB) begin
               st[d][b]  = seen;
               run[d][b] = 0;
               if (seen) begin
                  rise[d][b] = n;
                  evr[d][b][(n + 2) % 4] = 1;
               end
            end
         end else begin
            run[d][b] = 0;
         end
      end
      m_busy[d] = bh2[d];
      bh2[d] = bh1[d];
      bh1[d] = st[d][0] | st[d][1];
      m_wrap[d] = 0;
      if (load_en) begin
         m_count[d] = int'(load_val);
      end else if (ev[0] && !ev[1]) begin
         m_wrap[d]  = (m_count[d] == 15);
         m_count[d] = (m_count[d] + 1) % 16;
      end else if (ev[1] && !ev[0]) begin
         m_wrap[d]  = (m_count[d] == 0);
         m_count[d] = (m_count[d] + 15) % 16;
      end
   endtask

   // Model consumes the inputs seen at each edge and queues the predicted outputs.
   always @(posedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) model_edge(d);
      e.val = 4'(m_count[0]); e.wrap = m_wrap[0]; e.busy = m_busy[0];
      expq0.push_back(e);
      e.val = 4'(m_count[1]); e.wrap = m_wrap[1]; e.busy = m_busy[1];
      expq1.push_back(e);
      edge_n++;
   end

   // ---------------- monitor ----------------
   task automatic compare(input string name, input exp_t act, input exp_t exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s @%0t: got val=%0d wrap=%b busy=%b, expected val=%0d wrap=%b busy=%b",
                  name, $time, act.val, act.wrap, act.busy, exp.val, exp.wrap, exp.busy);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq0.size() > 0) begin
         e = expq0.pop_front();
         compare("dut0_cycle", {out0, wrap0, busy0}, e);
      end
      if (expq1.size() > 0) begin
         e = expq1.pop_front();
         compare("dut1_cycle", {out1, wrap1, busy1}, e);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spot(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic do_load(input logic [3:0] v);
      load_val = v; load_en = 1'b1; tick(1);
      load_en = 1'b0; tick(1);
   endtask

   task automatic press(input bit which);
      if (which) btn_dec_raw = 1'b1; else btn_inc_raw = 1'b1;
      tick(8);
      btn_inc_raw = 1'b0; btn_dec_raw = 1'b0;
      tick(12);
   endtask

   initial begin
      tick(3);
      rst = 1'b0;
      tick(2);

      // clean press
      press(0);
      spot("clean_press", out0, 4'd1);

      // bounce then settle
      for (int i = 0; i < 6; i++) begin
         btn_inc_raw = (i % 2 == 0);
         tick(1);
      end
      press(0);
      spot("bounce_single_step", out0, 4'd2);

      // wrap both directions
      do_load(4'd15);
      press(0);
      spot("wrap_up", out0, 4'd0);
      press(1);
      spot("wrap_down", out1, 4'd15);

      // simultaneous inc/dec
      do_load(4'd5);
      btn_inc_raw = 1'b1; btn_dec_raw = 1'b1;
      tick(8);
      btn_inc_raw = 1'b0; btn_dec_raw = 1'b0;
      tick(12);
      spot("simultaneous", out0, 4'd5);

      // load lands on the same edge as the inc event
      btn_inc_raw = 1'b1;
      tick(7);
      load_val = 4'd9; load_en = 1'b1;
      tick(1);
      load_en = 1'b0; btn_inc_raw = 1'b0;
      tick(12);
      spot("load_priority", out0, 4'd9);

      // auto-repeat hold
      do_load(4'd0);
      btn_inc_raw = 1'b1;
      tick(30);
      btn_inc_raw = 1'b0;
      tick(15);
      spot("repeat_norpt", out0, 4'd1);
      spot("repeat_count", out1, 4'd8);

      // reset in the middle of a debounce window
      do_load(4'd7);
      btn_inc_raw = 1'b1;
      tick(4);
      rst = 1'b1; btn_inc_raw = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(15);
      spot("reset_mid_debounce", out0, 4'd0);

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         int len;
         btn_inc_raw = 1'($urandom_range(0, 1));
         btn_dec_raw = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 24);
         for (int c = 0; c < len; c++) begin
            load_en  = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            rst      = ($urandom_range(0, 127) == 0);
            tick(1);
         end
         load_en = 1'b0;
         rst     = 1'b0;
      end

      btn_inc_raw = 1'b0; btn_dec_raw = 1'b0;
      tick(20);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
